// File: rtl/adder_seq_pkg.sv
// Shared constants and state encoding for the byte-serial wide adder.
package adder_seq_pkg;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte index is at least one bit wide, even for a single-byte operand.
  function automatic int idx_width(input int nbytes);
    return $clog2((nbytes < 2) ? 2 : nbytes);
  endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Operand/result handshake bundle for adder_seq_ctrl.
// The sub signal exists only when ADDSEQ_SUB_EN is defined.
interface adder_seq_ctrl_if
  import adder_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
);
  localparam int W = BYTE_W * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef ADDSEQ_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

`ifdef ADDSEQ_SUB_EN
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
`else
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
`endif

endinterface

// File: rtl/adder8.sv
// 8-bit ripple-carry adder, purely combinational.
module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [8:0] c;

  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign co = c[8];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide add done one byte per cycle on a shared adder8, LSB byte first.
// Optional subtract mode is enabled with the ADDSEQ_SUB_EN macro.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
)(
  input logic               clk,
  input logic               rst,
  adder_seq_ctrl_if.slave   bus
);

  localparam int W    = BYTE_W * NBYTES;
  localparam int IDXW = idx_width(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic [W-1:0]      sum_reg;
  logic              carry_reg;
  logic [IDXW-1:0]   idx_reg;
  logic [W-1:0]      b_eff;
  logic              carry_init;
  logic              accept;

  logic [BYTE_W-1:0] a_byte    [NBYTES];
  logic [BYTE_W-1:0] beff_byte [NBYTES];
  logic [BYTE_W-1:0] add_a;
  logic [BYTE_W-1:0] add_b;
  logic [BYTE_W-1:0] add_s;
  logic              add_co;

`ifdef ADDSEQ_SUB_EN
  logic sub_reg;

  // Subtract is a + ~b + 1; cin is ignored in that mode.
  assign b_eff      = sub_reg ? ~b_reg : b_reg;
  assign carry_init = bus.sub ? 1'b1 : bus.cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_reg <= 1'b0;
    end else if (accept) begin
      sub_reg <= bus.sub;
    end
  end
`else
  assign b_eff      = b_reg;
  assign carry_init = bus.cin;
`endif

  assign accept = (state_reg == IDLE) && bus.in_valid;

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign a_byte[gi]    = a_reg[gi*BYTE_W +: BYTE_W];
      assign beff_byte[gi] = b_eff[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  assign add_a = a_byte[idx_reg];
  assign add_b = beff_byte[idx_reg];

  adder8 u_adder8 (
    .a  (add_a),
    .b  (add_b),
    .ci (carry_reg),
    .s  (add_s),
    .co (add_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)       state_next = RUN;
      RUN:     if (idx_reg == LAST_IDX) state_next = DONE;
      DONE:    if (bus.out_ready)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs depend on state only.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_reg)
      IDLE: bus.in_ready = 1'b1;
      RUN:  bus.busy     = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= bus.b;
      carry_reg <= carry_init;
      idx_reg   <= '0;
    end else if (state_reg == RUN) begin
      sum_reg[idx_reg*BYTE_W +: BYTE_W] <= add_s;
      carry_reg                         <= add_co;
      if (idx_reg != LAST_IDX) begin
        idx_reg <= idx_reg + IDXW'(1);
      end
    end
  end

  assign bus.sum  = sum_reg;
  assign bus.cout = carry_reg;
  assign bus.ovf  = (a_reg[W-1] == b_eff[W-1]) && (sum_reg[W-1] != a_reg[W-1]);

endmodule

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

Multi-cycle sequencer that performs a wide (8×NBYTES-bit) addition by time-sharing a single 8-bit ripple adder (`adder8`) one byte per cycle, least-significant byte first. The byte carry is chained through a register. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is the standard way to reuse the 8-bit adder datapath for 16/32/64-bit arithmetic.

## Interface
- `NBYTES`, default 4: operand width in bytes, ≥1. W = 8×NBYTES.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands presented.
- `in_ready`  out  1  block can accept operands.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `cin`  in  1  carry into byte 0.
- `sub`  in  1  subtract select. Present only with `ADDSEQ_SUB_EN`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `sum`  out  W  result.
- `cout`  out  1  carry out of the MSB byte.
- `ovf`  out  1  two's-complement overflow.
- `busy`  out  1  high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid` is high, capture `a`, `b` and `cin` into registers, clear byte index `idx` to 0, and go to RUN.
- **RUN**
  - Each cycle the adder sees a_reg byte `idx`, b_reg byte `idx` and carry_reg.
  - On the clock edge:
    - the adder output is written to sum_reg byte `idx`;
    - carry_reg takes the adder carry;
    - `idx` increments.
  - When `idx`=NBYTES−1, go to DONE instead of incrementing.
- **DONE**
  - `out_valid`=1.
  - `sum`, `cout` and `ovf` are held stable while `out_ready`=0.
  - When `out_ready`=1, go to IDLE.
- `in_ready`=0 in RUN and DONE; `in_valid` in those states is ignored and no data is captured.
- `cout` = final carry_reg.
- `ovf` = (a_reg[W−1] == b_eff[W−1]) && (sum[W−1] != a_reg[W−1]), where b_eff is the B value actually fed to the adder.
- `idx` width is clog2(max(NBYTES,2)).
- With NBYTES=1, RUN lasts exactly one cycle.
- Reset values:
  - state IDLE;
  - `in_ready`=1;
  - `out_valid`=0, `busy`=0;
  - `sum`=0, `cout`=0, `ovf`=0;
  - all internal registers 0.
- Reset asserted in RUN or DONE aborts the operation; no `out_valid` is produced.

## Timing
- Accept edge: the rising edge with state IDLE && `in_valid`.
- `out_valid` rises NBYTES cycles after the accept edge.
- The earliest next accept is 1 cycle after the `out_valid`&&`out_ready` edge. Minimum issue interval is NBYTES+2 cycles.
- `in_ready`, `out_valid` and `busy` are decoded from state only, with no combinational path from `in_valid` or `out_ready`.
- `sum` bytes update progressively during RUN. They are valid only while `out_valid`=1.

## Configuration
- Macro: `ADDSEQ_SUB_EN`.
- **Defined**
  - The `sub` port exists and is captured at accept.
  - When sub=1, b_eff = ~b and the initial carry is 1; `cin` is ignored.
  - `cout`=1 means no borrow.
- **Undefined**
  - No `sub` port.
  - b_eff = b and the initial carry is `cin`.

## Structure
- Shared package/header `adder_seq_pkg`:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default NBYTES;
  - byte-width constant 8.
- One sub-module instance: the existing `adder8`, connected combinationally to the byte-select muxes of a_reg/b_eff and to carry_reg.
- The FSM, index counter and byte-select muxes stay in `adder_seq_ctrl`.

## Test plan
All scenarios use NBYTES=4.
- **Basic add:** a=3, b=5, cin=0 → `out_valid` 4 cycles after accept, sum=0x00000008, cout=0, ovf=0.
- **Carry chaining:** a=0x000000FF, b=0x00000001 → sum=0x00000100, cout=0. Then a=0xFFFFFFFF, b=1 → sum=0, cout=1, ovf=0.
- **Signed overflow:** a=0x7FFFFFFF, b=1 → sum=0x80000000, ovf=1, cout=0. Then cin=1 with a=b=0 → sum=1.
- **Backpressure:** hold out_ready=0 for 3 cycles after `out_valid` while driving in_valid=1 with new operands. Required: sum/cout stable, in_ready=0, no capture. After the out_ready=1 edge, state is IDLE and the next accept produces a correct result.
- **Reset mid-operation:** assert rst in the 2nd RUN cycle. Required: out_valid=0, in_ready=1, sum=0 immediately (async). A subsequent operation completes correctly.
- **Subtract (`ADDSEQ_SUB_EN` only):** sub=1, a=5, b=3 → sum=2, cout=1. Then sub=1, a=3, b=5 → sum=0xFFFFFFFE, cout=0.
